// File: rtl/parity_monitor_if.sv
// Parity monitor bus: per-RAM flags, mask and FIFO write enable in;
// armed flag, summaries, error map, counter and first-error capture out.
interface parity_monitor_if #(
  parameter int NRAM = 37,
  parameter int CNTB = 16,
  parameter int IDXB = 6
);
  logic [NRAM-1:0] parity_err;
  logic [NRAM-1:0] perr_mask;
  logic            fifo_wen;
  logic            perr_en;
  logic            perr;
  logic            perr_pulse;
  logic            perr_ff;
  logic [NRAM-1:0] perr_ram_ff;
  logic [CNTB-1:0] perr_cnt;
  logic            perr_first_vld;
  logic [IDXB-1:0] perr_first_idx;
  logic [CNTB-1:0] perr_first_time;

  // RAM-bank / sequencer side: drives flags and sees status.
  modport master (
    output parity_err, perr_mask, fifo_wen,
    input  perr_en, perr, perr_pulse, perr_ff, perr_ram_ff, perr_cnt,
           perr_first_vld, perr_first_idx, perr_first_time
  );

  // Monitor side.
  modport slave (
    input  parity_err, perr_mask, fifo_wen,
    output perr_en, perr, perr_pulse, perr_ff, perr_ram_ff, perr_cnt,
           perr_first_vld, perr_first_idx, perr_first_time
  );
endinterface

// File: rtl/parity_monitor.sv
// Parity-error monitor for raw-hits and miniscope RAMs. Arms after the
// raw-hits FIFO has been written ARM_CNT+1 consecutive cycles, then
// latches a per-RAM error map, a saturating error-cycle count and a
// one-shot capture of the first error (lowest RAM index, armed-cycle time).
// IDXB must satisfy 2**IDXB >= NRAM; ARMB must satisfy 2**ARMB > ARM_CNT.
module parity_monitor #(
  parameter int NRAM    = 37,
  parameter int ARM_CNT = 4096,
  parameter int CNTB    = 16,
  parameter int IDXB    = 6,
  parameter int ARMB    = 13
) (
  input  logic             clock,
  input  logic             global_reset,
  input  logic             perr_reset,
  parity_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    WAIT     = 2'd0,
    ARMED    = 2'd1,
    CAPTURED = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            rst;
  logic [NRAM-1:0] err_vec;
  logic            perr;
  logic [IDXB-1:0] low_idx;
  logic [ARMB-1:0] arm_cnt;
  logic [CNTB-1:0] tstamp;
  logic            arm_done;
  logic            capture;
  logic            en_nxt;

  logic            perr_en;
  logic            perr_pulse;
  logic            perr_ff;
  logic [NRAM-1:0] perr_ram_ff;
  logic [CNTB-1:0] perr_cnt;
  logic            first_vld;
  logic [IDXB-1:0] first_idx;
  logic [CNTB-1:0] first_time;

  assign rst = global_reset | perr_reset;

  // Masked error vector and live summary; no register, so zero latency.
  assign err_vec = bus.parity_err & ~bus.perr_mask;
  assign perr    = |err_vec;

  // Lowest set index of the masked error vector (priority to bit 0).
  always_comb begin
    low_idx = '0;
    for (int i = NRAM - 1; i >= 0; i--) begin
      if (err_vec[i]) low_idx = IDXB'(i);
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (rst) state <= WAIT;
    else     state <= state_nxt;
  end

  // Next-state: arm after a full unbroken FIFO fill, capture on first error.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:     if (arm_done) state_nxt = ARMED;
      ARMED:    if (perr)     state_nxt = CAPTURED;
      CAPTURED: state_nxt = CAPTURED;
      default:  state_nxt = WAIT;
    endcase
  end

  // Decoded controls. perr_en is registered from the next state so it
  // tracks state exactly; an error in the rising cycle sees perr_en=0.
  always_comb begin
    arm_done = 1'b0;
    capture  = 1'b0;
    en_nxt   = (state_nxt != WAIT);
    case (state)
      WAIT:    arm_done = bus.fifo_wen && (arm_cnt == ARMB'(ARM_CNT));
      ARMED:   capture  = perr;
      default: ;
    endcase
  end

  // Arming counter: counts consecutive write cycles, any gap restarts it.
  // It cannot pass ARM_CNT because reaching it with fifo_wen=1 leaves WAIT.
  always_ff @(posedge clock) begin
    if (rst || state != WAIT || !bus.fifo_wen) arm_cnt <= '0;
    else                                      arm_cnt <= arm_cnt + ARMB'(1);
  end

  // Armed-cycle timestamp: 0 on the first armed cycle, saturating.
  always_ff @(posedge clock) begin
    if (rst || state == WAIT)  tstamp <= '0;
    else if (tstamp != '1)     tstamp <= tstamp + CNTB'(1);
  end

  // Armed flag and registered error pulse.
  always_ff @(posedge clock) begin
    if (rst) begin
      perr_en    <= 1'b0;
      perr_pulse <= 1'b0;
    end else begin
      perr_en    <= en_nxt;
      perr_pulse <= perr & perr_en;
    end
  end

  // Error latches, only while armed. The map is held clear while disarmed;
  // a masked error is never recorded, so unmasking cannot resurrect it.
  always_ff @(posedge clock) begin
    if (rst) begin
      perr_ff     <= 1'b0;
      perr_ram_ff <= '0;
      perr_cnt    <= '0;
    end else if (!perr_en) begin
      perr_ram_ff <= '0;
    end else begin
      perr_ff     <= perr_ff | perr;
      perr_ram_ff <= perr_ram_ff | err_vec;
      if (perr && perr_cnt != '1) perr_cnt <= perr_cnt + CNTB'(1);
    end
  end

  // First-error capture, loaded once on the ARMED->CAPTURED transition.
  always_ff @(posedge clock) begin
    if (rst) begin
      first_vld  <= 1'b0;
      first_idx  <= '0;
      first_time <= '0;
    end else if (capture) begin
      first_vld  <= 1'b1;
      first_idx  <= low_idx;
      first_time <= tstamp;
    end
  end

  assign bus.perr_en         = perr_en;
  assign bus.perr            = perr;
  assign bus.perr_pulse      = perr_pulse;
  assign bus.perr_ff         = perr_ff;
  assign bus.perr_ram_ff     = perr_ram_ff;
  assign bus.perr_cnt        = perr_cnt;
  assign bus.perr_first_vld  = first_vld;
  assign bus.perr_first_idx  = first_idx;
  assign bus.perr_first_time = first_time;

endmodule

// File: tb/tb_parity_monitor.sv
// Directed bench for parity_monitor: reset, arming with and without a
// write gap, masking, first-error capture, counter saturation, and
// perr_reset while captured. ARM_CNT=8, CNTB=4 keep the runs short.
module tb_parity_monitor;
  localparam int NRAM    = 37;
  localparam int ARM_CNT = 8;
  localparam int CNTB    = 4;
  localparam int IDXB    = 6;
  localparam int ARMB    = 4;

  logic clock = 1'b0;
  logic global_reset;
  logic perr_reset;
  int   checks = 0;
  int   errors = 0;
  logic [NRAM-1:0] exp_map;

  parity_monitor_if #(.NRAM(NRAM), .CNTB(CNTB), .IDXB(IDXB)) bus ();

  parity_monitor #(
    .NRAM(NRAM), .ARM_CNT(ARM_CNT), .CNTB(CNTB), .IDXB(IDXB), .ARMB(ARMB)
  ) dut (
    .clock(clock),
    .global_reset(global_reset),
    .perr_reset(perr_reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // One clock: outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".perr_en"},    64'(bus.perr_en), 64'd0);
    chk({tag, ".pulse"},      64'(bus.perr_pulse), 64'd0);
    chk({tag, ".perr_ff"},    64'(bus.perr_ff), 64'd0);
    chk({tag, ".ram_ff"},     64'(bus.perr_ram_ff), 64'd0);
    chk({tag, ".cnt"},        64'(bus.perr_cnt), 64'd0);
    chk({tag, ".first_vld"},  64'(bus.perr_first_vld), 64'd0);
    chk({tag, ".first_idx"},  64'(bus.perr_first_idx), 64'd0);
    chk({tag, ".first_time"}, 64'(bus.perr_first_time), 64'd0);
  endtask

  initial begin
    global_reset   = 1'b1;
    perr_reset     = 1'b0;
    bus.parity_err = '0;
    bus.perr_mask  = '0;
    bus.fifo_wen   = 1'b0;
    step(2);

    // Reset values; perr stays combinational during reset.
    chk_reset_vals("reset");
    bus.parity_err[3] = 1'b1;
    #1;
    chk("perr_in_reset", 64'(bus.perr), 64'd1);
    bus.parity_err = '0;
    global_reset   = 1'b0;

    // Errors during WAIT are not latched.
    bus.parity_err[5] = 1'b1;
    step(3);
    chk("prearm.perr_en", 64'(bus.perr_en), 64'd0);
    chk("prearm.perr_ff", 64'(bus.perr_ff), 64'd0);
    chk("prearm.ram_ff",  64'(bus.perr_ram_ff), 64'd0);
    chk("prearm.cnt",     64'(bus.perr_cnt), 64'd0);
    chk("prearm.pulse",   64'(bus.perr_pulse), 64'd0);
    bus.parity_err = '0;

    // Clean arm: fifo_wen high from edge 0, perr_en rises after edge 8.
    bus.fifo_wen = 1'b1;
    step(8);
    chk("arm.before_edge8", 64'(bus.perr_en), 64'd0);
    step(1);
    chk("arm.after_edge8", 64'(bus.perr_en), 64'd1);

    // perr_reset returns to WAIT.
    perr_reset   = 1'b1;
    bus.fifo_wen = 1'b0;
    step(1);
    chk("prst.perr_en", 64'(bus.perr_en), 64'd0);
    perr_reset = 1'b0;

    // Gap at edge 5 restarts the count; counting resumes at edge 6 as a
    // new edge 0, so perr_en rises after edge 14. An error in the cycle
    // before that edge is sampled with perr_en=0 and must be ignored.
    bus.fifo_wen = 1'b1;
    step(5);
    bus.fifo_wen = 1'b0;
    step(1);
    bus.fifo_wen = 1'b1;
    step(8);
    chk("gap.edge13", 64'(bus.perr_en), 64'd0);
    bus.parity_err[7] = 1'b1;
    step(1);
    chk("gap.edge14",      64'(bus.perr_en), 64'd1);
    chk("armedge.perr_ff", 64'(bus.perr_ff), 64'd0);
    chk("armedge.cnt",     64'(bus.perr_cnt), 64'd0);
    chk("armedge.pulse",   64'(bus.perr_pulse), 64'd0);
    chk("armedge.vld",     64'(bus.perr_first_vld), 64'd0);
    bus.parity_err = '0;
    bus.fifo_wen   = 1'b0;

    // Armed cycle tstamp=0: masked error is invisible.
    bus.perr_mask[12]  = 1'b1;
    bus.parity_err[12] = 1'b1;
    #1;
    chk("mask.perr", 64'(bus.perr), 64'd0);
    step(1);
    chk("mask.cnt",    64'(bus.perr_cnt), 64'd0);
    chk("mask.ram12",  64'(bus.perr_ram_ff[12]), 64'd0);
    chk("mask.vld",    64'(bus.perr_first_vld), 64'd0);
    chk("mask.pulse",  64'(bus.perr_pulse), 64'd0);
    bus.parity_err = '0;
    bus.perr_mask  = '0;

    // Now tstamp=1; two more cycles, then bits 12 and 31 at tstamp=3.
    step(2);
    bus.parity_err[12] = 1'b1;
    bus.parity_err[31] = 1'b1;
    #1;
    chk("cap.perr_live", 64'(bus.perr), 64'd1);
    step(1);
    exp_map = '0;
    exp_map[12] = 1'b1;
    exp_map[31] = 1'b1;
    chk("cap.vld",     64'(bus.perr_first_vld), 64'd1);
    chk("cap.idx",     64'(bus.perr_first_idx), 64'd12);
    chk("cap.time",    64'(bus.perr_first_time), 64'd3);
    chk("cap.ram_ff",  64'(bus.perr_ram_ff), 64'(exp_map));
    chk("cap.cnt",     64'(bus.perr_cnt), 64'd1);
    chk("cap.pulse",   64'(bus.perr_pulse), 64'd1);
    chk("cap.perr_ff", 64'(bus.perr_ff), 64'd1);
    bus.parity_err = '0;
    step(1);
    chk("cap.pulse_single", 64'(bus.perr_pulse), 64'd0);

    // Later error on bit 2 does not overwrite the capture.
    bus.parity_err[2] = 1'b1;
    step(1);
    exp_map[2] = 1'b1;
    chk("later.idx",    64'(bus.perr_first_idx), 64'd12);
    chk("later.time",   64'(bus.perr_first_time), 64'd3);
    chk("later.ram_ff", 64'(bus.perr_ram_ff), 64'(exp_map));
    chk("later.cnt",    64'(bus.perr_cnt), 64'd2);
    bus.parity_err = '0;

    // Saturation: 20 more error cycles on a 4-bit counter stop at 15.
    bus.parity_err[0] = 1'b1;
    step(20);
    chk("sat.cnt", 64'(bus.perr_cnt), 64'd15);
    step(2);
    chk("sat.hold", 64'(bus.perr_cnt), 64'd15);

    // perr_reset with an error present while CAPTURED: back to reset values.
    bus.parity_err[4] = 1'b1;
    perr_reset = 1'b1;
    step(1);
    chk_reset_vals("capreset");
    perr_reset = 1'b0;

    // Must re-arm through WAIT: errors still present are not latched.
    step(3);
    chk("rearm.perr_en", 64'(bus.perr_en), 64'd0);
    chk("rearm.cnt",     64'(bus.perr_cnt), 64'd0);
    chk("rearm.ram_ff",  64'(bus.perr_ram_ff), 64'd0);
    bus.parity_err = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/parity_monitor.md
# parity_monitor

Parametrised parity-error monitor for TMB raw-hits and miniscope RAMs; successor to the fixed five-CFEB/RPC/mini parity block. It accepts a flat vector of NRAM per-RAM parity flags and arms only after the raw-hits FIFO has written every address. When armed it produces:
- a maskable live summary and a latched per-RAM error map;
- a saturating error-cycle counter;
- a capture of the first error: which RAM, and how many cycles after arming.

It sits between the CFEB/RPC/miniscope RAM banks and the sequencer/VME status registers.

## Interface
- NRAM, 37: number of parity flags; default is 30 CFEB + 5 RPC + 2 mini.
- ARM_CNT, 4096: consecutive fifo_wen cycles required before arming.
- CNTB, 16: width of the error counter and the timestamp counter.
- IDXB, 6: width of the RAM index; must satisfy 2**IDXB >= NRAM.
- ARMB, 13: width of the arming counter; must satisfy 2**ARMB > ARM_CNT.

- clock  in  1  40 MHz TMB main clock.
- global_reset  in  1  synchronous, active-high reset.
- perr_reset  in  1  synchronous, active-high; clears latches and forces re-arming.
- parity_err  in  NRAM  per-RAM parity error flags, one bit per RAM.
- perr_mask  in  NRAM  1 = ignore that RAM.
- fifo_wen  in  1  raw-hits FIFO write enable.
- perr_en  out  1  monitor armed.
- perr  out  1  combinational OR of parity_err & ~perr_mask.
- perr_pulse  out  1  registered one-cycle pulse, perr & perr_en.
- perr_ff  out  1  latched summary.
- perr_ram_ff  out  NRAM  latched per-RAM error map.
- perr_cnt  out  CNTB  saturating count of cycles with an armed error.
- perr_first_vld  out  1  first-error capture valid.
- perr_first_idx  out  IDXB  lowest unmasked RAM index in error on the first-error cycle.
- perr_first_time  out  CNTB  armed-cycle timestamp of the first error.

## Operation
- reset = global_reset | perr_reset. Reset has priority over every other event in the same cycle.
- State machine, states WAIT / ARMED / CAPTURED (reset state is WAIT). perr_en = (state != WAIT), registered.
- WAIT:
  - arm_cnt increments on each fifo_wen=1 cycle and clears to 0 on any fifo_wen=0 cycle.
  - When arm_cnt == ARM_CNT and fifo_wen=1, go to ARMED.
  - arm_cnt is held at 0 outside WAIT.
- ARMED:
  - tstamp increments each cycle, saturating at 2**CNTB-1.
  - On a cycle with perr=1: go to CAPTURED. Load perr_first_idx with the lowest set index of parity_err & ~perr_mask, load perr_first_time with the current tstamp, and set perr_first_vld.
- CAPTURED: hold until reset. Later errors never overwrite the capture.
- Latching applies only while perr_en=1:
  - perr_ram_ff |= parity_err & ~perr_mask;
  - perr_ff |= perr;
  - perr_cnt += 1 when perr, saturating at all ones with no wrap.
- Whenever perr_en=0, perr_ram_ff is cleared.
- perr_mask is applied combinationally every cycle. Unmasking a RAM does not recover errors it had while masked.
- tstamp counts from 0 on the first ARMED cycle.

## Timing
- Reset values, one cycle after reset: perr_en=0, perr_pulse=0, perr_ff=0, perr_ram_ff=0, perr_cnt=0, perr_first_vld=0, perr_first_idx=0, perr_first_time=0. perr follows its inputs with no reset.
- Arming: with fifo_wen held high starting at edge 0, arm_cnt==ARM_CNT after edge ARM_CNT-1, and perr_en=1 after edge ARM_CNT.
- An error on the same cycle that perr_en rises is ignored, because perr_en was still 0 when it was sampled.
- Latency from parity_err to perr is 0 cycles. Latency to perr_pulse, perr_ff, perr_ram_ff, perr_cnt and the capture registers is 1 clock.
- perr_reset mid-error clears everything on the next edge; the monitor must then re-arm through WAIT.
- A fifo_wen gap of one cycle during WAIT restarts the arming count from 0.

## Test plan
- Reset/arm: hold fifo_wen=1 for ARM_CNT=8 cycles with no errors -> perr_en rises after edge 8. Insert a one-cycle fifo_wen=0 at cycle 5 -> perr_en delayed to 8 edges after the gap.
- First capture: arm, wait 3 cycles, then assert parity_err bits 12 and 31 for one cycle. Expect:
  - perr_first_vld=1, perr_first_idx=12, perr_first_time=3;
  - perr_ram_ff bits 12 and 31 set; perr_cnt=1; a single perr_pulse.
  - A later error on bit 2 leaves perr_first_idx at 12.
- Mask: set perr_mask[12]=1 and drive parity_err[12]=1 while armed -> perr=0, perr_cnt=0, perr_ram_ff[12]=0, perr_first_vld=0.
- Saturation: CNTB=4, hold an error for 20 armed cycles -> perr_cnt=15 and stays 15.
- Pre-arm and reset: errors during WAIT -> all latches 0. While CAPTURED, assert perr_reset together with an error -> all outputs return to reset values and perr_en=0.
